// File: rtl/ef_i2c_apb_arbiter.sv
// Round-robin arbiter sharing one APB completer between two requesters, with per-requester lock and lock-idle timeout.
// Latency: PSEL seen at T -> m_PSEL at T+1 -> m_PENABLE at T+2; a non-owner simply sees PREADY low until served.
module ef_i2c_apb_arbiter #(
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        s0_PSEL,
  input  logic        s0_PENABLE,
  input  logic        s0_PWRITE,
  input  logic [31:0] s0_PADDR,
  input  logic [31:0] s0_PWDATA,
  input  logic        s0_PLOCK,
  output logic        s0_PREADY,
  output logic [31:0] s0_PRDATA,
  input  logic        s1_PSEL,
  input  logic        s1_PENABLE,
  input  logic        s1_PWRITE,
  input  logic [31:0] s1_PADDR,
  input  logic [31:0] s1_PWDATA,
  input  logic        s1_PLOCK,
  output logic        s1_PREADY,
  output logic [31:0] s1_PRDATA,
  output logic        m_PSEL,
  output logic        m_PENABLE,
  output logic        m_PWRITE,
  output logic [31:0] m_PADDR,
  output logic [31:0] m_PWDATA,
  input  logic        m_PREADY,
  input  logic [31:0] m_PRDATA,
  output logic [1:0]  grant_o,
  output logic        locked_o,
  output logic        lock_timeout_o
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, LOCKED} state_e;

  localparam logic [15:0] TO_LAST = 16'(LOCK_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [1:0]  grant_q, grant_d;
  logic [15:0] cnt_q, cnt_d;
  logic        to_q, to_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        pwrite_q, pwrite_d;
  logic        cap, cap_sel;
  logic        own_psel, own_plock;
  logic        done;
  logic        unused_penable;

  // Arbitration looks only at PSEL; PENABLE carries no information for us.
  assign unused_penable = s0_PENABLE ^ s1_PENABLE;

  assign own_psel  = owner_q ? s1_PSEL  : s0_PSEL;
  assign own_plock = owner_q ? s1_PLOCK : s0_PLOCK;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      grant_q  <= 2'b00;
      cnt_q    <= 16'd0;
      to_q     <= 1'b0;
      paddr_q  <= 32'd0;
      pwdata_q <= 32'd0;
      pwrite_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      to_q     <= to_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    grant_d = grant_q;
    cnt_d   = 16'd0;
    to_d    = 1'b0;
    cap     = 1'b0;
    cap_sel = owner_q;
    case (state_q)
      IDLE: begin
        if (s0_PSEL || s1_PSEL) begin
          // On a tie the requester that was not served last wins.
          cap_sel = (s0_PSEL && s1_PSEL) ? ~last_q : s1_PSEL;
          cap     = 1'b1;
          owner_d = cap_sel;
          last_d  = cap_sel;
          grant_d = cap_sel ? 2'b10 : 2'b01;
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (m_PREADY) begin
          if (own_plock) begin
            state_d = LOCKED;
          end else begin
            state_d = IDLE;
            grant_d = 2'b00;
          end
        end
      end
      LOCKED: begin
        if (own_psel) begin
          cap     = 1'b1;
          state_d = SETUP;
        end else if (!own_plock) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end else if (cnt_q == TO_LAST) begin
          state_d = IDLE;
          grant_d = 2'b00;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    paddr_d  = cap ? (cap_sel ? s1_PADDR  : s0_PADDR)  : paddr_q;
    pwdata_d = cap ? (cap_sel ? s1_PWDATA : s0_PWDATA) : pwdata_q;
    pwrite_d = cap ? (cap_sel ? s1_PWRITE : s0_PWRITE) : pwrite_q;
  end

  always_comb begin
    m_PSEL    = (state_q == SETUP) || (state_q == ACCESS);
    m_PENABLE = (state_q == ACCESS);
    locked_o  = (state_q == LOCKED);
    done      = (state_q == ACCESS) && m_PREADY;
    // An owner that dropped PSEL mid-transfer gets no response.
    s0_PREADY = done && grant_q[0] && s0_PSEL;
    s1_PREADY = done && grant_q[1] && s1_PSEL;
    s0_PRDATA = s0_PREADY ? m_PRDATA : 32'd0;
    s1_PRDATA = s1_PREADY ? m_PRDATA : 32'd0;
  end

  assign m_PADDR        = paddr_q;
  assign m_PWDATA       = pwdata_q;
  assign m_PWRITE       = pwrite_q;
  assign grant_o        = grant_q;
  assign lock_timeout_o = to_q;

endmodule

// File: tb/tb_ef_i2c_apb_arbiter.sv
// Bench for ef_i2c_apb_arbiter: requester drivers plus a simple downstream completer with programmable wait states.
// Expected transfers are queued in grant order and matched as each requester completes.
module tb_ef_i2c_apb_arbiter;

  localparam int LT = 8;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;

  logic [1:0]       s_psel, s_pen, s_pwr, s_lock;
  logic [1:0][31:0] s_addr, s_wdata;
  wire  [1:0]       s_rdy;
  wire  [1:0][31:0] s_rdata;

  wire        m_PSEL, m_PENABLE, m_PWRITE;
  wire [31:0] m_PADDR, m_PWDATA;
  wire        m_PREADY;
  wire [31:0] m_PRDATA;
  wire [1:0]  grant_o;
  wire        locked_o, lock_timeout_o;

  int wait_cycles = 0;
  int acc_cnt = 0;
  bit rd_mode = 1'b0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int          n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];

  ef_i2c_apb_arbiter #(.LOCK_TIMEOUT(LT)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .s0_PSEL(s_psel[0]), .s0_PENABLE(s_pen[0]), .s0_PWRITE(s_pwr[0]),
    .s0_PADDR(s_addr[0]), .s0_PWDATA(s_wdata[0]), .s0_PLOCK(s_lock[0]),
    .s0_PREADY(s_rdy[0]), .s0_PRDATA(s_rdata[0]),
    .s1_PSEL(s_psel[1]), .s1_PENABLE(s_pen[1]), .s1_PWRITE(s_pwr[1]),
    .s1_PADDR(s_addr[1]), .s1_PWDATA(s_wdata[1]), .s1_PLOCK(s_lock[1]),
    .s1_PREADY(s_rdy[1]), .s1_PRDATA(s_rdata[1]),
    .m_PSEL(m_PSEL), .m_PENABLE(m_PENABLE), .m_PWRITE(m_PWRITE),
    .m_PADDR(m_PADDR), .m_PWDATA(m_PWDATA),
    .m_PREADY(m_PREADY), .m_PRDATA(m_PRDATA),
    .grant_o(grant_o), .locked_o(locked_o), .lock_timeout_o(lock_timeout_o)
  );

  always #5 PCLK = ~PCLK;

  // Downstream completer: ready after wait_cycles ACCESS cycles, read data derived from the address.
  assign m_PREADY = m_PENABLE && (acc_cnt >= wait_cycles);
  assign m_PRDATA = rd_mode ? 32'hDEADBEEF : (m_PADDR ^ 32'h5A5A5A5A);

  always @(posedge PCLK) acc_cnt <= (m_PENABLE && !m_PREADY) ? acc_cnt + 1 : 0;

  function automatic exp_t mk(input int n, input logic [31:0] a, input logic [31:0] w, input logic wr);
    exp_t e;
    e.n = n; e.addr = a; e.wdata = w; e.wr = wr;
    e.rdata = rd_mode ? 32'hDEADBEEF : (a ^ 32'h5A5A5A5A);
    return e;
  endfunction

  // Called just after a rising edge; returns just after the edge that ends the transfer.
  task automatic xfer(input int n, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic wr, input logic lk, output int lat);
    exp_t e;
    logic [1:0] g;
    s_psel[n] = 1'b1; s_pen[n] = 1'b0; s_addr[n] = addr;
    s_wdata[n] = wdata; s_pwr[n] = wr; s_lock[n] = lk;
    lat = 0;
    @(negedge PCLK);
    while (s_rdy[n] !== 1'b1 && lat < 300) begin
      s_pen[n] = 1'b1;
      lat++;
      @(negedge PCLK);
    end
    checks++;
    if (s_rdy[n] !== 1'b1) begin
      errors++;
      $display("FAIL xfer_timeout s%0d: PREADY=%b after %0d cycles, required 1", n, s_rdy[n], lat);
    end else if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_empty s%0d completed addr=%h, no transfer expected", n, m_PADDR);
    end else begin
      e = exp_q.pop_front();
      g = (n == 1) ? 2'b10 : 2'b01;
      checks += 6;
      if (e.n != n) begin
        errors++; $display("FAIL order: completed s%0d, required s%0d", n, e.n);
      end
      if (m_PADDR !== e.addr) begin
        errors++; $display("FAIL m_paddr s%0d: got %h, required %h", n, m_PADDR, e.addr);
      end
      if (m_PWRITE !== e.wr || m_PWDATA !== e.wdata) begin
        errors++; $display("FAIL m_write s%0d: got %b/%h, required %b/%h", n, m_PWRITE, m_PWDATA, e.wr, e.wdata);
      end
      if (grant_o !== g) begin
        errors++; $display("FAIL grant s%0d: got %b, required %b", n, grant_o, g);
      end
      if (s_rdata[n] !== e.rdata) begin
        errors++; $display("FAIL prdata s%0d: got %h, required %h", n, s_rdata[n], e.rdata);
      end
      if (s_rdy[1-n] !== 1'b0 || s_rdata[1-n] !== 32'd0) begin
        errors++; $display("FAIL nonowner s%0d: PREADY=%b PRDATA=%h, required 0/0", 1-n, s_rdy[1-n], s_rdata[1-n]);
      end
    end
    @(posedge PCLK); #1;
    s_psel[n] = 1'b0; s_pen[n] = 1'b0;
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    repeat (3) @(negedge PCLK);
    checks++;
    if ({m_PSEL, m_PENABLE, m_PWRITE, m_PADDR, m_PWDATA, grant_o, locked_o, lock_timeout_o, s_rdy, s_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: psel=%b en=%b wr=%b addr=%h wd=%h grant=%b lk=%b to=%b rdy=%b rd0=%h rd1=%h, required all 0",
               m_PSEL, m_PENABLE, m_PWRITE, m_PADDR, m_PWDATA, grant_o, locked_o, lock_timeout_o, s_rdy, s_rdata[0], s_rdata[1]);
    end
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
  endtask

  task automatic test_tie();
    int l0, l1;
    exp_q.push_back(mk(0, 32'h0000_0004, 32'h0000_0011, 1'b1));
    exp_q.push_back(mk(1, 32'h0000_0008, 32'h0000_0022, 1'b0));
    exp_q.push_back(mk(0, 32'h0000_000C, 32'h0000_0033, 1'b0));
    exp_q.push_back(mk(1, 32'h0000_FF10, 32'h0000_0044, 1'b1));
    fork
      begin
        xfer(0, 32'h0000_0004, 32'h0000_0011, 1'b1, 1'b0, l0);
        checks++;
        if (l0 != 2) begin
          errors++; $display("FAIL tie_first_latency: got %0d, required 2", l0);
        end
        xfer(0, 32'h0000_000C, 32'h0000_0033, 1'b0, 1'b0, l0);
      end
      begin
        xfer(1, 32'h0000_0008, 32'h0000_0022, 1'b0, 1'b0, l1);
        xfer(1, 32'h0000_FF10, 32'h0000_0044, 1'b1, 1'b0, l1);
      end
    join
  endtask

  task automatic test_single();
    int lat;
    exp_q.push_back(mk(0, 32'h0000_FF00, 32'h0000_01FF, 1'b1));
    fork
      xfer(0, 32'h0000_FF00, 32'h0000_01FF, 1'b1, 1'b0, lat);
      begin
        @(negedge PCLK);
        checks++;
        if (m_PSEL !== 1'b0 || grant_o !== 2'b00) begin
          errors++; $display("FAIL single_T0: m_PSEL=%b grant=%b, required 0/00", m_PSEL, grant_o);
        end
        @(negedge PCLK);
        checks++;
        if (m_PSEL !== 1'b1 || m_PENABLE !== 1'b0 || grant_o !== 2'b01) begin
          errors++; $display("FAIL single_T1: psel=%b en=%b grant=%b, required 1/0/01", m_PSEL, m_PENABLE, grant_o);
        end
        @(negedge PCLK);
        checks++;
        if (m_PSEL !== 1'b1 || m_PENABLE !== 1'b1 || s_rdy[1] !== 1'b0) begin
          errors++; $display("FAIL single_T2: psel=%b en=%b s1_rdy=%b, required 1/1/0", m_PSEL, m_PENABLE, s_rdy[1]);
        end
      end
    join
    checks++;
    if (lat != 2) begin
      errors++; $display("FAIL single_latency: got %0d, required 2", lat);
    end
  endtask

  task automatic test_lock();
    int l0, l1;
    for (int k = 0; k < 3; k++) exp_q.push_back(mk(0, 32'h0000_0100 + 32'(4 * k), 32'h0000_0A00 + 32'(k), 1'b1));
    exp_q.push_back(mk(1, 32'h0000_0200, 32'h0000_0B00, 1'b1));
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          xfer(0, 32'h0000_0100 + 32'(4 * k), 32'h0000_0A00 + 32'(k), 1'b1, 1'b1, l0);
          @(negedge PCLK);
          checks++;
          if (locked_o !== 1'b1 || grant_o !== 2'b01 || m_PSEL !== 1'b0) begin
            errors++; $display("FAIL lock_hold %0d: locked=%b grant=%b psel=%b, required 1/01/0", k, locked_o, grant_o, m_PSEL);
          end
        end
        s_lock[0] = 1'b0;
      end
      begin
        @(posedge PCLK); #1;
        xfer(1, 32'h0000_0200, 32'h0000_0B00, 1'b1, 1'b0, l1);
      end
    join
  endtask

  task automatic test_timeout();
    int l0, l1, i;
    exp_q.push_back(mk(0, 32'h0000_0300, 32'h0000_0C00, 1'b1));
    exp_q.push_back(mk(1, 32'h0000_0304, 32'h0000_0D00, 1'b0));
    fork
      begin
        xfer(0, 32'h0000_0300, 32'h0000_0C00, 1'b1, 1'b1, l0);
        i = 0;
        @(negedge PCLK);
        checks++;
        if (locked_o !== 1'b1) begin
          errors++; $display("FAIL timeout_locked: locked=%b, required 1", locked_o);
        end
        while (lock_timeout_o !== 1'b1 && i < 20) begin
          i++;
          @(negedge PCLK);
        end
        checks++;
        if (i != LT) begin
          errors++; $display("FAIL timeout_delay: pulse after %0d cycles, required %0d", i, LT);
        end
        checks++;
        if (locked_o !== 1'b0 || grant_o !== 2'b00) begin
          errors++; $display("FAIL timeout_release: locked=%b grant=%b, required 0/00", locked_o, grant_o);
        end
        @(negedge PCLK);
        checks++;
        if (lock_timeout_o !== 1'b0 || grant_o !== 2'b10 || m_PSEL !== 1'b1) begin
          errors++; $display("FAIL timeout_regrant: pulse=%b grant=%b psel=%b, required 0/10/1", lock_timeout_o, grant_o, m_PSEL);
        end
        s_lock[0] = 1'b0;
      end
      begin
        @(posedge PCLK); #1;
        xfer(1, 32'h0000_0304, 32'h0000_0D00, 1'b0, 1'b0, l1);
      end
    join
  endtask

  task automatic test_wait();
    int lat;
    rd_mode = 1'b1;
    wait_cycles = 5;
    exp_q.push_back(mk(0, 32'h0000_0010, 32'h0000_0000, 1'b0));
    xfer(0, 32'h0000_0010, 32'h0000_0000, 1'b0, 1'b0, lat);
    checks++;
    if (lat != 7) begin
      errors++; $display("FAIL wait_latency: got %0d, required 7", lat);
    end
    rd_mode = 1'b0;
    wait_cycles = 0;
  endtask

  task automatic test_async_reset();
    int i, lat;
    wait_cycles = 20;
    s_psel[0] = 1'b1; s_addr[0] = 32'h0000_FF04; s_wdata[0] = 32'h0000_0055;
    s_pwr[0] = 1'b1; s_lock[0] = 1'b1;
    i = 0;
    @(negedge PCLK);
    while (m_PENABLE !== 1'b1 && i < 10) begin
      i++;
      @(negedge PCLK);
    end
    checks++;
    if (m_PENABLE !== 1'b1 || m_PWRITE !== 1'b1) begin
      errors++; $display("FAIL areset_access: en=%b wr=%b, required 1/1", m_PENABLE, m_PWRITE);
    end
    #2 PRESETn = 1'b0;
    #1;
    checks++;
    if ({m_PSEL, m_PENABLE, m_PWRITE, m_PADDR, m_PWDATA, grant_o, locked_o, lock_timeout_o, s_rdy, s_rdata} !== '0) begin
      errors++;
      $display("FAIL areset_outputs: psel=%b en=%b wr=%b addr=%h wd=%h grant=%b lk=%b rdy=%b, required all 0",
               m_PSEL, m_PENABLE, m_PWRITE, m_PADDR, m_PWDATA, grant_o, locked_o, s_rdy);
    end
    s_psel[0] = 1'b0; s_pen[0] = 1'b0; s_lock[0] = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    wait_cycles = 0;
    exp_q.push_back(mk(1, 32'h0000_FF08, 32'h0000_00A5, 1'b0));
    xfer(1, 32'h0000_FF08, 32'h0000_00A5, 1'b0, 1'b0, lat);
    checks++;
    if (lat != 2) begin
      errors++; $display("FAIL areset_recover_latency: got %0d, required 2", lat);
    end
  endtask

  initial begin
    s_psel = '0; s_pen = '0; s_pwr = '0; s_lock = '0;
    s_addr = '0; s_wdata = '0;
    test_reset();
    test_tie();
    test_single();
    test_lock();
    test_timeout();
    test_wait();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover: %0d transfers never completed, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
